// File: rtl/score_arbiter_pkg.sv
// Shared state encodings and weight-code lookup for the score arbiter.
package score_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WeightOne      = 2'd0,
    WeightTen      = 2'd1,
    WeightHundred  = 2'd2,
    WeightThousand = 2'd3
  } weight_e;

  localparam int unsigned DefaultMaxScore = 9999;

  function automatic logic [9:0] weight_value(logic [1:0] code);
    logic [9:0] val;
    unique case (weight_e'(code))
      WeightOne:      val = 10'd1;
      WeightTen:      val = 10'd10;
      WeightHundred:  val = 10'd100;
      WeightThousand: val = 10'd1000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/score_arbiter_rr.sv
// Round-robin arbiter: first eligible (req & mask) source at or after the pointer wins.
module score_arbiter_rr #(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0]  ptr_q, ptr_d, win, cand;
  logic [N_REQ-1:0] eligible;
  logic             found;

  assign eligible = req & mask;

  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        win         = cand;
      end
    end
    ptr_d = (win == PtrW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// Game score register: round-robin point-add grants scaled by a combo multiplier, saturating.
module score_arbiter
  import score_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SCORE_W     = 32,
  parameter int unsigned MAX_SCORE   = DefaultMaxScore,
  parameter int unsigned COMBO_SHIFT = 3,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               game_over,
  input  logic               miss,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] weight,
  output logic [N_REQ-1:0]   ack,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [2:0]         mult,
  output logic               score_update,
  output logic [1:0]         state
);

  localparam int unsigned SumW = SCORE_W + 4;

  state_e             state_q;
  logic [N_REQ-1:0]   ack_q, grant, mask;
  logic [SCORE_W-1:0] score_q, capped;
  logic [7:0]         combo_q, combo_d;
  logic [2:0]         mult_q;
  logic               update_q, granted;
  logic [1:0]         sel_code;
  logic [SumW-1:0]    points, product, sum;

  function automatic logic [2:0] mult_of(logic [7:0] c);
    int unsigned m;
    m = 1 + (32'(c) >> COMBO_SHIFT);
    if (m > MAX_MULT) m = MAX_MULT;
    return 3'(m);
  endfunction

  // A source acked last cycle is masked so a held req is not counted twice.
  assign mask    = (state_q == StRun && !pause) ? ~ack_q : '0;
  assign granted = |grant;

  score_arbiter_rr #(
    .N_REQ(N_REQ)
  ) u_rr (
    .clock(clock),
    .reset(reset),
    .req  (req),
    .mask (mask),
    .grant(grant)
  );

  always_comb begin
    sel_code = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_code = weight[2*i +: 2];
    end
  end

  // mult is at most 4, so the scaling is a sum of shifted copies.
  always_comb begin
    points  = SumW'(weight_value(sel_code));
    product = (mult_q[0] ? points : '0)
            + (mult_q[1] ? (points << 1) : '0)
            + (mult_q[2] ? (points << 2) : '0);
    sum     = SumW'(score_q) + product;
    capped  = (sum >= SumW'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
  end

  always_comb begin
    combo_d = combo_q;
    if ((state_q == StIdle || state_q == StDone) && start) begin
      combo_d = '0;
    end else if (state_q == StRun || state_q == StPause) begin
      if (miss) begin
        combo_d = '0;
      end else if (granted) begin
        combo_d = (combo_q == 8'hff) ? 8'hff : combo_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      score_q  <= '0;
      combo_q  <= '0;
      mult_q   <= 3'd1;
      ack_q    <= '0;
      update_q <= 1'b0;
    end else begin
      ack_q    <= grant;
      update_q <= 1'b0;
      combo_q  <= combo_d;
      mult_q   <= mult_of(combo_d);
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q  <= StRun;
            score_q  <= '0;
            update_q <= (score_q != '0);
          end
        end
        StRun: begin
          if (granted) begin
            score_q  <= capped;
            update_q <= (capped != score_q);
          end
          if (game_over)  state_q <= StDone;
          else if (pause) state_q <= StPause;
        end
        StPause: begin
          if (game_over)   state_q <= StDone;
          else if (!pause) state_q <= StRun;
        end
      endcase
    end
  end

  assign ack          = ack_q;
  assign score        = score_q;
  assign combo        = combo_q;
  assign mult         = mult_q;
  assign score_update = update_q;
  assign state        = state_q;

endmodule

// File: tb/tb_score_arbiter.sv
// Directed bench for score_arbiter with hand-computed expectations.
module tb_score_arbiter;

  logic        clock = 1'b0;
  logic        reset, start, pause, game_over, miss;
  logic [3:0]  req;
  logic [7:0]  weight;
  logic [3:0]  ack;
  logic [31:0] score;
  logic [7:0]  combo;
  logic [2:0]  mult;
  logic        score_update;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  score_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .game_over   (game_over),
    .miss        (miss),
    .req         (req),
    .weight      (weight),
    .ack         (ack),
    .score       (score),
    .combo       (combo),
    .mult        (mult),
    .score_update(score_update),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, 64'(state), 64'd0);
    check({tag, " score"}, 64'(score), 64'd0);
    check({tag, " combo"}, 64'(combo), 64'd0);
    check({tag, " mult"}, 64'(mult), 64'd1);
    check({tag, " ack"}, 64'(ack), 64'd0);
    check({tag, " update"}, 64'(score_update), 64'd0);
  endtask

  task automatic grant_once(input logic [1:0] code);
    weight = {6'd0, code};
    tick();  // grant edge
    tick();  // ack cycle: source masked
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0; miss = 1'b0;
    req = '0; weight = '0;
    tick(); tick();
    check_reset_values("reset");
    reset = 1'b0;

    // 1: single +10 grant
    start = 1'b1; tick(); start = 1'b0;
    check("t1 state run", 64'(state), 64'd1);
    req = 4'b0001; weight = 8'b0000_0001;
    tick();
    check("t1 ack", 64'(ack), 64'b0001);
    check("t1 score", 64'(score), 64'd10);
    check("t1 update", 64'(score_update), 64'd1);
    check("t1 combo", 64'(combo), 64'd1);
    req = '0;
    tick();
    check("t1 ack drop", 64'(ack), 64'd0);
    check("t1 update drop", 64'(score_update), 64'd0);

    // 2: all four held, rotation 0,1,2,3,0,...
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    req = 4'b1111; weight = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t2 ack %0d", i), 64'(ack), 64'(4'b0001 << (i % 4)));
      check($sformatf("t2 score %0d", i), 64'(score), 64'(i + 1));
    end
    // 3: combo 8 -> mult 2
    check("t3 combo8", 64'(combo), 64'd8);
    check("t3 mult2", 64'(mult), 64'd2);
    tick();
    check("t3 9th ack", 64'(ack), 64'b0001);
    check("t3 9th score", 64'(score), 64'd10);
    miss = 1'b1;
    tick();
    miss = 1'b0; req = '0;
    check("t3 10th ack", 64'(ack), 64'b0010);
    check("t3 10th score", 64'(score), 64'd12);
    check("t3 miss combo", 64'(combo), 64'd0);
    check("t3 miss mult", 64'(mult), 64'd1);
    tick();

    // 4: build 9990 at mult 1 (miss each grant), then saturate
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    req = 4'b0001; miss = 1'b1;
    for (int i = 0; i < 9; i++) grant_once(2'd3);
    for (int i = 0; i < 9; i++) grant_once(2'd2);
    for (int i = 0; i < 9; i++) grant_once(2'd1);
    check("t4 score 9990", 64'(score), 64'd9990);
    check("t4 mult 1", 64'(mult), 64'd1);
    miss = 1'b0; weight = 8'd2;
    tick();
    check("t4 sat ack", 64'(ack), 64'b0001);
    check("t4 sat score", 64'(score), 64'd9999);
    check("t4 sat update", 64'(score_update), 64'd1);
    weight = 8'd3;
    tick();
    tick();
    check("t4 post-sat ack", 64'(ack), 64'b0001);
    check("t4 post-sat score", 64'(score), 64'd9999);
    check("t4 post-sat update", 64'(score_update), 64'd0);
    check("t4 post-sat combo", 64'(combo), 64'd2);

    // 5: pause, resume, game_over with pause
    req = '0; tick();
    pause = 1'b1; req = 4'b0001;
    tick();
    check("t5 paused state", 64'(state), 64'd2);
    check("t5 paused ack", 64'(ack), 64'd0);
    tick();
    check("t5 paused ack2", 64'(ack), 64'd0);
    check("t5 paused combo", 64'(combo), 64'd2);
    pause = 1'b0;
    tick();
    check("t5 resume state", 64'(state), 64'd1);
    check("t5 resume no ack", 64'(ack), 64'd0);
    tick();
    check("t5 resume ack", 64'(ack), 64'b0001);
    check("t5 resume combo", 64'(combo), 64'd3);
    req = '0; tick();
    game_over = 1'b1; pause = 1'b1; req = 4'b0001;
    tick();
    check("t5 done state", 64'(state), 64'd3);
    check("t5 done ack", 64'(ack), 64'd0);
    game_over = 1'b0; pause = 1'b0;
    tick();
    check("t5 done ack2", 64'(ack), 64'd0);
    check("t5 done score", 64'(score), 64'd9999);

    // 6: restart from DONE, then reset during an ack
    req = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t6 restart state", 64'(state), 64'd1);
    check("t6 restart score", 64'(score), 64'd0);
    check("t6 restart combo", 64'(combo), 64'd0);
    check("t6 restart update", 64'(score_update), 64'd1);
    req = 4'b0001; weight = 8'd0;
    tick();
    check("t6 ack before reset", 64'(ack), 64'b0001);
    reset = 1'b1;
    tick();
    check_reset_values("t6 reset mid-ack");
    reset = 1'b0; req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
